// File: rtl/handshake_pkg.sv
// Shared definitions for the A->B handshake link: beat geometry, packed-word
// type and handshake FSM states used by both Device A and Device B.
package handshake_pkg;

    localparam int HS_DATA_W = 16;
    localparam int HS_WORDS  = 4;

    typedef logic [HS_DATA_W*HS_WORDS-1:0] hs_pkt_t;
    typedef logic [HS_DATA_W-1:0]          hs_beat_t;

    typedef enum logic [0:0] {
        HS_IDLE = 1'b0,
        HS_ACK  = 1'b1
    } hs_state_t;

endpackage : handshake_pkg

// File: rtl/device_b_rx_if.sv
// Bus bundle for Device B: the capture handshake from Device A and the
// valid/ready beat stream to the downstream consumer.
interface device_b_rx_if #(
    parameter int DATA_W = 16,
    parameter int WORDS  = 4
);
    logic                      readyA;
    logic [DATA_W*WORDS-1:0]   in_pkt;
    logic                      acceptedB;
    logic [DATA_W-1:0]         out_B;
    logic                      validB;
    logic                      readyB;

    // Environment side: Device A plus the downstream consumer.
    modport master (
        output readyA,
        output in_pkt,
        output readyB,
        input  acceptedB,
        input  out_B,
        input  validB
    );

    // Device B side.
    modport slave (
        input  readyA,
        input  in_pkt,
        input  readyB,
        output acceptedB,
        output out_B,
        output validB
    );
endinterface : device_b_rx_if

// File: rtl/hs_word_unpacker.sv
// Holds one captured packed word and streams it out low beat first over a
// valid/ready interface; reports empty so the capture FSM can refill it.
module hs_word_unpacker #(
    parameter int DATA_W = 16,
    parameter int WORDS  = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    load_i,
    input  logic [DATA_W*WORDS-1:0] pkt_i,
    input  logic                    ready_i,
    output logic                    empty_o,
    output logic                    valid_o,
    output logic [DATA_W-1:0]       data_o
);

    localparam int          IDX_W    = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);

    logic [DATA_W*WORDS-1:0] buf_q,  buf_d;
    logic [IDX_W-1:0]        idx_q,  idx_d;
    logic                    full_q, full_d;
    logic [DATA_W-1:0]       data_q, data_d;
    logic [IDX_W-1:0]        nxt_idx_s;

    assign nxt_idx_s = idx_q + IDX_W'(1);

    // Next-state: load wins; otherwise a beat handshake advances or drains.
    always_comb begin
        buf_d  = buf_q;
        idx_d  = idx_q;
        full_d = full_q;
        data_d = data_q;
        if (load_i) begin
            buf_d  = pkt_i;
            idx_d  = '0;
            full_d = 1'b1;
            data_d = pkt_i[DATA_W-1:0];
        end else if (full_q && ready_i) begin
            if (idx_q == LAST_IDX) begin
                idx_d  = '0;
                full_d = 1'b0;
                data_d = '0;
            end else begin
                idx_d  = nxt_idx_s;
                data_d = buf_q[nxt_idx_s*DATA_W +: DATA_W];
            end
        end else begin
            full_d = full_q;
        end
    end

    // Buffer, beat index and output beat registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            buf_q  <= '0;
            idx_q  <= '0;
            full_q <= 1'b0;
            data_q <= '0;
        end else begin
            buf_q  <= buf_d;
            idx_q  <= idx_d;
            full_q <= full_d;
            data_q <= data_d;
        end
    end

    assign empty_o = ~full_q;
    assign valid_o = full_q;
    assign data_o  = data_q;

endmodule : hs_word_unpacker

// File: rtl/device_b_rx.sv
// Device B receive stage: four-phase capture handshake with Device A, capture
// counter, and a word unpacker feeding the downstream beat stream.
module device_b_rx
    import handshake_pkg::*;
#(
    parameter int DATA_W = HS_DATA_W,
    parameter int WORDS  = HS_WORDS
) (
    input  logic          clk,
    input  logic          rst,
    device_b_rx_if.slave  bus,
    output logic          busyB,
    output logic [7:0]    xfer_cnt
);

    hs_state_t   state_q, state_d;
    logic        acc_q,   acc_d;
    logic [7:0]  cnt_q,   cnt_d;
    logic        load_s;
    logic        empty_s;

    // Handshake FSM: capture only from IDLE into an empty buffer, then hold
    // the acknowledge until Device A drops its request.
    always_comb begin
        state_d = state_q;
        acc_d   = 1'b0;
        load_s  = 1'b0;
        case (state_q)
            HS_IDLE: begin
                if (bus.readyA && empty_s) begin
                    load_s  = 1'b1;
                    acc_d   = 1'b1;
                    state_d = HS_ACK;
                end else begin
                    state_d = HS_IDLE;
                end
            end
            HS_ACK: begin
                if (bus.readyA) begin
                    acc_d   = 1'b1;
                    state_d = HS_ACK;
                end else begin
                    state_d = HS_IDLE;
                end
            end
            default: begin
                state_d = HS_IDLE;
            end
        endcase
    end

    // Capture counter wraps naturally at 8 bits.
    always_comb begin
        if (load_s) begin
            cnt_d = cnt_q + 8'd1;
        end else begin
            cnt_d = cnt_q;
        end
    end

    // FSM state, acknowledge and counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= HS_IDLE;
            acc_q   <= 1'b0;
            cnt_q   <= 8'd0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
        end
    end

    hs_word_unpacker #(
        .DATA_W (DATA_W),
        .WORDS  (WORDS)
    ) u_unpacker (
        .clk     (clk),
        .rst     (rst),
        .load_i  (load_s),
        .pkt_i   (bus.in_pkt),
        .ready_i (bus.readyB),
        .empty_o (empty_s),
        .valid_o (bus.validB),
        .data_o  (bus.out_B)
    );

    assign bus.acceptedB = acc_q;
    assign busyB         = ~empty_s;
    assign xfer_cnt      = cnt_q;

endmodule : device_b_rx

// File: tb/tb_device_b_rx.sv
// Self-checking bench for device_b_rx: directed scenarios plus randomized
// back-to-back traffic against a queue-based behavioural model.
module tb_device_b_rx;

    logic       clk = 1'b0;
    logic       rst;
    logic       busyB;
    logic [7:0] xfer_cnt;

    device_b_rx_if #(.DATA_W(16), .WORDS(4)) bus ();

    device_b_rx dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus),
        .busyB    (busyB),
        .xfer_cnt (xfer_cnt)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;
    bit rnd_rb = 1'b0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Behavioural model: the buffer is a queue of pending beats, the ack is a
    // single flag that stays up as long as the request does.
    logic [15:0] m_q[$];
    bit          m_ack;
    int          m_cnt;
    int          m_beats;
    int          dut_beats;

    always @(posedge clk) begin
        bit cap;
        if (bus.validB === 1'b1 && bus.readyB && !rst) dut_beats++;
        if (rst) begin
            m_q.delete();
            m_ack = 1'b0;
            m_cnt = 0;
            m_beats = 0;
            dut_beats = 0;
        end else begin
            cap = !m_ack && bus.readyA && (m_q.size() == 0);
            if (m_q.size() != 0 && bus.readyB) begin
                void'(m_q.pop_front());
                m_beats++;
            end
            if (cap) begin
                for (int i = 0; i < 4; i++) m_q.push_back(bus.in_pkt[16*i +: 16]);
                m_cnt = (m_cnt + 1) % 256;
            end
            m_ack = cap ? 1'b1 : (m_ack && bus.readyA);
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check_eq("m_acc",   bus.acceptedB, m_ack);
            check_eq("m_valid", bus.validB, m_q.size() != 0);
            check_eq("m_busy",  busyB, m_q.size() != 0);
            check_eq("m_cnt",   xfer_cnt, m_cnt);
            if (m_q.size() != 0) check_eq("m_beat", bus.out_B, m_q[0]);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        if (rnd_rb) bus.readyB = ($urandom_range(0, 3) != 0);
    endtask

    task automatic wait_acc(input logic lvl, input string tag);
        int n = 0;
        while (bus.acceptedB !== lvl && n < 40) begin
            tick();
            n++;
        end
        check_eq(tag, bus.acceptedB, lvl);
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((bus.validB !== 1'b0 || bus.acceptedB !== 1'b0) && n < 40) begin
            tick();
            n++;
        end
        check_eq("idle_valid", bus.validB, 1'b0);
    endtask

    initial begin
        rst        = 1'b1;
        bus.readyA = 1'b0;
        bus.in_pkt = 64'h0;
        bus.readyB = 1'b1;
        tick();
        tick();
        chk_en = 1'b1;
        check_eq("rst_acc",   bus.acceptedB, 1'b0);
        check_eq("rst_valid", bus.validB, 1'b0);
        check_eq("rst_out",   bus.out_B, 16'h0);
        check_eq("rst_busy",  busyB, 1'b0);
        check_eq("rst_cnt",   xfer_cnt, 8'd0);
        rst = 1'b0;

        // Single transfer with readyA high for three cycles.
        bus.in_pkt = 64'h0004_0003_0002_0001;
        bus.readyA = 1'b1;
        tick();
        check_eq("s_acc0", bus.acceptedB, 1'b1);
        check_eq("s_val0", bus.validB, 1'b1);
        check_eq("s_busy", busyB, 1'b1);
        check_eq("s_out1", bus.out_B, 16'h0001);
        tick();
        check_eq("s_out2", bus.out_B, 16'h0002);
        check_eq("s_acc1", bus.acceptedB, 1'b1);
        tick();
        check_eq("s_out3", bus.out_B, 16'h0003);
        check_eq("s_acc2", bus.acceptedB, 1'b1);
        bus.readyA = 1'b0;
        tick();
        check_eq("s_out4", bus.out_B, 16'h0004);
        check_eq("s_acc3", bus.acceptedB, 1'b0);
        tick();
        check_eq("s_valE", bus.validB, 1'b0);
        check_eq("s_cnt",  xfer_cnt, 8'd1);

        // Downstream stall on beat 0.
        bus.readyB = 1'b0;
        bus.readyA = 1'b1;
        tick();
        bus.readyA = 1'b0;
        for (int i = 0; i < 6; i++) begin
            check_eq("st_out", bus.out_B, 16'h0001);
            check_eq("st_val", bus.validB, 1'b1);
            if (i < 5) tick();
        end
        bus.readyB = 1'b1;
        for (int j = 2; j <= 4; j++) begin
            tick();
            check_eq("st_beat", bus.out_B, 16'(j));
        end
        tick();
        check_eq("st_valE", bus.validB, 1'b0);
        check_eq("st_cnt",  xfer_cnt, 8'd2);

        // Back-pressure: second request while the buffer is still full.
        bus.readyB = 1'b0;
        bus.in_pkt = 64'h0008_0007_0006_0005;
        bus.readyA = 1'b1;
        tick();
        bus.readyA = 1'b0;
        tick();
        bus.in_pkt = 64'hDDDD_CCCC_BBBB_AAAA;
        bus.readyA = 1'b1;
        repeat (3) begin
            tick();
            check_eq("bp_acc",  bus.acceptedB, 1'b0);
            check_eq("bp_busy", busyB, 1'b1);
        end
        bus.readyB = 1'b1;
        repeat (4) tick();
        check_eq("bp_noacc", bus.acceptedB, 1'b0);
        check_eq("bp_empty", bus.validB, 1'b0);
        tick();
        check_eq("bp_acc1", bus.acceptedB, 1'b1);
        check_eq("bp_A",    bus.out_B, 16'hAAAA);
        bus.readyA = 1'b0;
        tick();
        check_eq("bp_B", bus.out_B, 16'hBBBB);
        tick();
        check_eq("bp_C", bus.out_B, 16'hCCCC);
        tick();
        check_eq("bp_D", bus.out_B, 16'hDDDD);
        tick();
        check_eq("bp_valE", bus.validB, 1'b0);
        check_eq("bp_cnt",  xfer_cnt, 8'd4);

        // Reset in the middle of unpacking.
        bus.in_pkt = {$urandom, $urandom};
        bus.readyA = 1'b1;
        tick();
        bus.readyA = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
        check_eq("mr_acc",  bus.acceptedB, 1'b0);
        check_eq("mr_val",  bus.validB, 1'b0);
        check_eq("mr_out",  bus.out_B, 16'h0);
        check_eq("mr_busy", busyB, 1'b0);
        check_eq("mr_cnt",  xfer_cnt, 8'd0);
        rst = 1'b0;
        repeat (3) begin
            tick();
            check_eq("mr_noold", bus.validB, 1'b0);
        end

        // readyA still high across reset is a fresh capture.
        bus.in_pkt = 64'h1234_5678_9ABC_DEF0;
        bus.readyA = 1'b1;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        check_eq("rr_acc", bus.acceptedB, 1'b1);
        check_eq("rr_out", bus.out_B, 16'hDEF0);
        check_eq("rr_cnt", xfer_cnt, 8'd1);
        bus.readyA = 1'b0;
        wait_idle();

        // Long readyA: one capture, ack held for the whole request.
        bus.readyA = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            check_eq("lr_acc", bus.acceptedB, 1'b1);
        end
        bus.readyA = 1'b0;
        tick();
        check_eq("lr_acc11", bus.acceptedB, 1'b0);
        check_eq("lr_cnt",   xfer_cnt, 8'd2);
        wait_idle();

        // 256 back-to-back random transfers with random downstream stalls.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        rnd_rb = 1'b1;
        for (int t = 0; t < 256; t++) begin
            bus.in_pkt = {$urandom, $urandom};
            bus.readyA = 1'b1;
            wait_acc(1'b1, "wr_acc_hi");
            bus.readyA = 1'b0;
            wait_acc(1'b0, "wr_acc_lo");
        end
        rnd_rb = 1'b0;
        bus.readyB = 1'b1;
        wait_idle();
        check_eq("wr_cnt",   xfer_cnt, 8'd0);
        check_eq("wr_beats", dut_beats, 32'd1024);
        check_eq("wr_model", m_beats, 32'd1024);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_device_b_rx
